// File: rtl/score_frame_packer.sv
// score_frame_packer
//
// Purpose: feeds the combinational signed max tree. Collects one signed
// score per cycle over a valid/ready stream and packs up to NUM scores into
// a flat NUM*LEN vector. The vector is held stable with a valid/ready
// handshake until the downstream stage consumes it. Slots that a short
// frame never writes hold the most-negative LEN-bit value, so they can
// never win the maximum.
//
// Ports:
//   clk        single clock, rising edge
//   rst_n      asynchronous active-low reset
//   s_valid    input score valid
//   s_ready    packer can accept a score (registered)
//   s_data     signed score, LEN bits
//   s_last     final score of a short frame, qualified by s_valid
//   vec_valid  packed vector complete and stable (registered)
//   vec_ready  downstream has consumed the vector
//   vec_data   slot i at bits [(i+1)*LEN-1 : i*LEN]
//   vec_count  number of real scores in the frame, 1..NUM

module score_frame_packer #(
   parameter int NUM = 300,
   parameter int LEN = 16,
   parameter int CW  = $clog2(NUM + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic signed [LEN-1:0] s_data,
   input  logic                  s_last,
   output logic                  vec_valid,
   input  logic                  vec_ready,
   output logic [NUM*LEN-1:0]    vec_data,
   output logic [CW-1:0]         vec_count
);

   localparam logic [LEN-1:0] MIN = {1'b1, {(LEN-1){1'b0}}};

   typedef enum logic [1:0] {
      CLR,
      FILL,
      HOLD
   } state_t;

   state_t          state, state_next;
   logic [CW-1:0]   cnt, cnt_next;
   logic            s_ready_next;
   logic            vec_valid_next;
   logic [CW-1:0]   vec_count_next;
   logic            clear_slots;
   logic            write_slot;
   logic            accept;
   logic            frame_end;

   // s_ready is registered and only ever 1 in FILL, so an accept can only
   // happen while filling.
   assign accept    = s_valid && s_ready;
   assign frame_end = accept && ((cnt == CW'(NUM - 1)) || s_last);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= CLR;
         cnt       <= '0;
         s_ready   <= 1'b0;
         vec_valid <= 1'b0;
         vec_count <= '0;
      end else begin
         state     <= state_next;
         cnt       <= cnt_next;
         s_ready   <= s_ready_next;
         vec_valid <= vec_valid_next;
         vec_count <= vec_count_next;
      end
   end

   always_comb begin
      state_next     = state;
      cnt_next       = cnt;
      s_ready_next   = s_ready;
      vec_valid_next = vec_valid;
      vec_count_next = vec_count;
      clear_slots    = 1'b0;
      write_slot     = 1'b0;

      unique case (state)
         CLR: begin
            clear_slots  = 1'b1;
            cnt_next     = '0;
            s_ready_next = 1'b1;
            state_next   = FILL;
         end
         FILL: begin
            if (accept) begin
               write_slot = 1'b1;
               cnt_next   = cnt + CW'(1);
               // Dropping s_ready on the final accept edge means the
               // upstream can never land a score in a frame being held.
               if (frame_end) begin
                  s_ready_next   = 1'b0;
                  vec_valid_next = 1'b1;
                  vec_count_next = cnt + CW'(1);
                  state_next     = HOLD;
               end
            end
         end
         HOLD: begin
            s_ready_next = 1'b0;
            if (vec_valid && vec_ready) begin
               vec_valid_next = 1'b0;
               state_next     = CLR;
            end
         end
         default: begin
            s_ready_next   = 1'b0;
            vec_valid_next = 1'b0;
            state_next     = CLR;
         end
      endcase
   end

   // Slot storage. Clearing every slot in CLR is what keeps a short frame
   // free of residue from the frame before it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vec_data <= {NUM{MIN}};
      end else if (clear_slots) begin
         vec_data <= {NUM{MIN}};
      end else if (write_slot) begin
         for (int i = 0; i < NUM; i++) begin
            if (cnt == CW'(i)) begin
               vec_data[i*LEN +: LEN] <= s_data;
            end
         end
      end
   end

endmodule

// File: tb/tb_score_frame_packer.sv
// tb_score_frame_packer
//
// Directed bench for score_frame_packer with NUM = 5, LEN = 8 (pad 0x80).
// Expected vectors are written out by hand; the max of the packed vector is
// compared against the hand-computed maximum of each frame.

module tb_score_frame_packer;

   localparam int NUM = 5;
   localparam int LEN = 8;
   localparam int CW  = $clog2(NUM + 1);

   logic                  clk;
   logic                  rst_n;
   logic                  s_valid;
   logic                  s_ready;
   logic signed [LEN-1:0] s_data;
   logic                  s_last;
   logic                  vec_valid;
   logic                  vec_ready;
   logic [NUM*LEN-1:0]    vec_data;
   logic [CW-1:0]         vec_count;

   int compared;
   int mismatched;
   int cycle;
   int accepts;
   int acc_cycle[$];

   score_frame_packer #(
      .NUM (NUM),
      .LEN (LEN)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_data    (s_data),
      .s_last    (s_last),
      .vec_valid (vec_valid),
      .vec_ready (vec_ready),
      .vec_data  (vec_data),
      .vec_count (vec_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycle counter and accept monitor, sampled on the edge the DUT uses.
   always @(posedge clk) begin
      cycle++;
      if (rst_n && s_valid && s_ready) begin
         accepts++;
         acc_cycle.push_back(cycle);
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [63:0] actual,
                              input logic [63:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int maxOf(input logic [NUM*LEN-1:0] v);
      int m;
      int x;
      m = -100000;
      for (int i = 0; i < NUM; i++) begin
         x = int'($signed(v[i*LEN +: LEN]));
         if (x > m) m = x;
      end
      return m;
   endfunction

   task automatic waitReady(input string tag);
      int n;
      n = 0;
      while (!s_ready && n < 20) begin
         tick();
         n++;
      end
      checkOutput(tag, 64'(s_ready), 64'd1);
   endtask

   // Presents one score as soon as the packer is ready and lets it be taken.
   task automatic applyStimulus(input logic [LEN-1:0] data, input logic last);
      waitReady("ready_before_send");
      s_valid = 1'b1;
      s_data  = data;
      s_last  = last;
      tick();
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic handshake();
      vec_ready = 1'b1;
      tick();
      vec_ready = 1'b0;
   endtask

   initial begin
      int maxv;
      bit [6:0] patt;
      logic [LEN-1:0] score;

      compared   = 0;
      mismatched = 0;
      cycle      = 0;
      accepts    = 0;
      rst_n      = 1'b0;
      s_valid    = 1'b0;
      s_data     = '0;
      s_last     = 1'b0;
      vec_ready  = 1'b0;

      // Reset values
      tick();
      tick();
      checkOutput("rst_s_ready",   64'(s_ready),   64'd0);
      checkOutput("rst_vec_valid", 64'(vec_valid), 64'd0);
      checkOutput("rst_vec_count", 64'(vec_count), 64'd0);
      checkOutput("rst_vec_data",  64'(vec_data),  64'h80_80_80_80_80);
      rst_n = 1'b1;

      // Full frame: 3, -7, 12, 0, 5 with vec_ready low for 4 cycles
      applyStimulus(8'h03, 1'b0);
      applyStimulus(8'hF9, 1'b0);
      applyStimulus(8'h0C, 1'b0);
      applyStimulus(8'h00, 1'b0);
      applyStimulus(8'h05, 1'b0);
      checkOutput("full_valid", 64'(vec_valid), 64'd1);
      checkOutput("full_data",  64'(vec_data),  64'h05_00_0C_F9_03);
      checkOutput("full_count", 64'(vec_count), 64'd5);
      checkOutput("full_ready", 64'(s_ready),   64'd0);
      maxv = maxOf(vec_data);
      checkOutput("full_max", 64'(maxv), 64'(12));
      for (int i = 0; i < 4; i++) begin
         tick();
         checkOutput("full_hold_valid", 64'(vec_valid), 64'd1);
         checkOutput("full_hold_data",  64'(vec_data),  64'h05_00_0C_F9_03);
      end
      handshake();
      checkOutput("full_drop_valid", 64'(vec_valid), 64'd0);
      checkOutput("full_clr_ready",  64'(s_ready),   64'd0);
      checkOutput("full_keep_count", 64'(vec_count), 64'd5);
      tick();
      checkOutput("full_ready_back", 64'(s_ready),  64'd1);
      checkOutput("full_cleared",    64'(vec_data), 64'h80_80_80_80_80);

      // Short frame: -3, -9 with s_last
      applyStimulus(8'hFD, 1'b0);
      applyStimulus(8'hF7, 1'b1);
      checkOutput("short_valid", 64'(vec_valid), 64'd1);
      checkOutput("short_data",  64'(vec_data),  64'h80_80_80_F7_FD);
      checkOutput("short_count", 64'(vec_count), 64'd2);
      maxv = maxOf(vec_data);
      checkOutput("short_max", 64'(maxv), 64'(-3));
      handshake();

      // Upstream gaps then a held stream
      waitReady("gap_ready_start");
      accepts = 0;
      patt    = 7'b1101101;
      score   = 8'd1;
      for (int i = 0; i < 7; i++) begin
         s_valid = patt[i];
         if (patt[i]) begin
            s_data = score;
            score  = score + 8'd1;
         end
         tick();
      end
      s_valid = 1'b1;
      s_data  = 8'h77;
      checkOutput("gap_accepts", 64'(accepts), 64'd5);
      checkOutput("gap_valid",   64'(vec_valid), 64'd1);
      checkOutput("gap_data",    64'(vec_data),  64'h05_04_03_02_01);
      for (int i = 0; i < 3; i++) begin
         checkOutput("gap_hold_ready", 64'(s_ready), 64'd0);
         tick();
      end
      handshake();
      checkOutput("gap_clr_ready", 64'(s_ready),   64'd0);
      checkOutput("gap_clr_valid", 64'(vec_valid), 64'd0);
      s_valid = 1'b0;
      tick();
      checkOutput("gap_ready_back",  64'(s_ready), 64'd1);
      checkOutput("gap_accepts_end", 64'(accepts), 64'd5);
      checkOutput("gap_count",       64'(vec_count), 64'd5);

      // Back-to-back frames with vec_ready tied high
      vec_ready = 1'b1;
      acc_cycle.delete();
      for (int i = 1; i <= 5; i++) applyStimulus(LEN'(i), 1'b0);
      checkOutput("b2b_a_data", 64'(vec_data), 64'h05_04_03_02_01);
      for (int i = 0; i < 5; i++) applyStimulus(8'h09, 1'b0);
      checkOutput("b2b_b_valid", 64'(vec_valid), 64'd1);
      checkOutput("b2b_b_data",  64'(vec_data),  64'h09_09_09_09_09);
      maxv = maxOf(vec_data);
      checkOutput("b2b_b_max", 64'(maxv), 64'(9));
      if (acc_cycle.size() >= 6)
         checkOutput("b2b_period", 64'(acc_cycle[5] - acc_cycle[0]), 64'd7);
      else
         checkOutput("b2b_accept_count", 64'(acc_cycle.size()), 64'd10);
      applyStimulus(8'h80, 1'b1);
      checkOutput("b2b_c_valid", 64'(vec_valid), 64'd1);
      checkOutput("b2b_c_data",  64'(vec_data),  64'h80_80_80_80_80);
      checkOutput("b2b_c_count", 64'(vec_count), 64'd1);
      maxv = maxOf(vec_data);
      checkOutput("b2b_c_max", 64'(maxv), 64'(-128));
      tick();
      vec_ready = 1'b0;

      // Reset in the middle of a frame
      applyStimulus(8'h11, 1'b0);
      applyStimulus(8'h22, 1'b0);
      applyStimulus(8'h33, 1'b0);
      rst_n = 1'b0;
      #2;
      checkOutput("midrst_ready", 64'(s_ready),   64'd0);
      checkOutput("midrst_valid", 64'(vec_valid), 64'd0);
      checkOutput("midrst_count", 64'(vec_count), 64'd0);
      checkOutput("midrst_data",  64'(vec_data),  64'h80_80_80_80_80);
      #3;
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) applyStimulus(LEN'(8'h41 + i), 1'b0);
      checkOutput("midrst_new_data",  64'(vec_data),  64'h45_44_43_42_41);
      checkOutput("midrst_new_count", 64'(vec_count), 64'd5);
      handshake();

      // Reset while holding a vector
      applyStimulus(8'h01, 1'b0);
      applyStimulus(8'h02, 1'b1);
      checkOutput("holdrst_pre_valid", 64'(vec_valid), 64'd1);
      rst_n = 1'b0;
      #2;
      checkOutput("holdrst_valid", 64'(vec_valid), 64'd0);
      checkOutput("holdrst_count", 64'(vec_count), 64'd0);
      checkOutput("holdrst_data",  64'(vec_data),  64'h80_80_80_80_80);
      #3;
      rst_n = 1'b1;
      waitReady("holdrst_ready_back");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
